command_stream_unpacker: RTL and testbench

Parametrised byte-granular unpacker between the GX command FIFO and the command processor. It buffers incoming FIFO words and hands out 0..OUT_BYTES byte fields per request. The stream is big- or little-endian ordered, and requests may either consume bytes or only peek at them. It replaces the fixed 32-bit/2-cycle deserializer with a single-cycle grant path, flush support and an explicit occupancy count.

---
 rtl/orca_cmd_pkg.sv | 22 ++
 rtl/byte_window_extract.sv | 32 +++
 rtl/command_stream_unpacker.sv | 100 ++++++++++
 tb/tb_command_stream_unpacker.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/orca_cmd_pkg.sv
// Shared types and width helpers for the GX command-stream path.
package orca_cmd_pkg;

  typedef enum logic {
    CMD_ENDIAN_LITTLE = 1'b0,
    CMD_ENDIAN_BIG    = 1'b1
  } cmd_endian_e;

  // Bits needed to hold a count in the inclusive range 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int buf_bytes(input int buf_words, input int in_bytes);
    return buf_words * in_bytes;
  endfunction

  localparam int DEF_IN_BYTES  = 4;
  localparam int DEF_BUF_WORDS = 2;
  localparam int DEF_BUF_BYTES = buf_bytes(DEF_BUF_WORDS, DEF_IN_BYTES);

endpackage

// File: rtl/byte_window_extract.sv
// Selects the n oldest bytes of the buffer (byte 0 = oldest), zero-extended,
// placing the oldest byte at the MSB end of the field (big) or at bits [7:0] (little).
module byte_window_extract
  import orca_cmd_pkg::*;
#(
  parameter int          BUF_BYTES = 8,
  parameter int          OUT_BYTES = 4,
  parameter cmd_endian_e ENDIAN    = CMD_ENDIAN_BIG,
  localparam int         CW        = cnt_width(OUT_BYTES)
) (
  input  logic [8*BUF_BYTES-1:0] buf_i,
  input  logic [CW-1:0]          n_i,
  output logic [8*OUT_BYTES-1:0] data_o
);

  logic [31:0] n_w;
  assign n_w = 32'(n_i);

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < OUT_BYTES; k++) begin
      if (k < n_w) begin
        if (ENDIAN == CMD_ENDIAN_BIG) begin
          data_o[8*(n_w-1-k) +: 8] = buf_i[8*k +: 8];
        end else begin
          data_o[8*k +: 8] = buf_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/command_stream_unpacker.sv
// Byte-granular unpacker: buffers command FIFO words and grants 0..OUT_BYTES byte
// fields per request in one cycle, with peek, flush and a registered occupancy count.
module command_stream_unpacker
  import orca_cmd_pkg::*;
#(
  parameter int  IN_BYTES   = 4,
  parameter int  OUT_BYTES  = 4,
  parameter int  BUF_WORDS  = 2,
  parameter int  BIG_ENDIAN = 1,
  localparam int BUF_BYTES  = buf_bytes(BUF_WORDS, IN_BYTES),
  localparam int CW         = cnt_width(OUT_BYTES),
  localparam int LW         = cnt_width(BUF_BYTES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic                   flush,
  input  logic                   req_valid,
  input  logic [CW-1:0]          req_bytes,
  input  logic                   req_peek,
  output logic                   req_ready,
  output logic                   out_valid,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic                   req_err,
  output logic [LW-1:0]          level
);

  logic [8*BUF_BYTES-1:0] buf_q, buf_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   out_valid_q, req_err_q;
  logic [8*OUT_BYTES-1:0] out_data_q, field;

  logic [31:0] lvl, req_w, eff, cons, keep;
  logic        oversize, push, grant, consume;

  assign lvl      = 32'(level_q);
  assign req_w    = 32'(req_bytes);
  assign oversize = req_w > 32'(OUT_BYTES);
  assign eff      = oversize ? 32'(OUT_BYTES) : req_w;

  // in_ready looks only at the registered level so the FIFO side never waits on req_*.
  assign in_ready  = ~flush & ((32'(BUF_BYTES) - lvl) >= 32'(IN_BYTES));
  assign push      = in_valid & in_ready;
  assign grant     = req_valid & ~flush & (lvl >= eff);
  assign req_ready = grant;
  assign consume   = grant & ~req_peek;
  assign cons      = consume ? eff : 32'd0;
  assign keep      = lvl - cons;

  always_comb begin
    buf_d = buf_q >> (8 * cons);
    if (push) begin
      for (int unsigned b = 0; b < IN_BYTES; b++) begin
        if (keep + b < 32'(BUF_BYTES)) begin
          buf_d[8*(keep+b) +: 8] = in_data[8*b +: 8];
        end
      end
    end
    level_d = flush ? '0 : LW'(keep + (push ? 32'(IN_BYTES) : 32'd0));
  end

  byte_window_extract #(
    .BUF_BYTES (BUF_BYTES),
    .OUT_BYTES (OUT_BYTES),
    .ENDIAN    ((BIG_ENDIAN != 0) ? CMD_ENDIAN_BIG : CMD_ENDIAN_LITTLE)
  ) u_extract (
    .buf_i  (buf_q),
    .n_i    (CW'(eff)),
    .data_o (field)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      req_err_q   <= 1'b0;
    end else begin
      level_q     <= level_d;
      out_valid_q <= grant;
      req_err_q   <= grant & oversize;
      if (grant) begin
        out_data_q <= field;
      end
    end
  end

  // Contents beyond level are don't-care, so the byte store needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign req_err   = req_err_q;
  assign level     = level_q;

endmodule

// File: tb/tb_command_stream_unpacker.sv
// Directed table bench: big- and little-endian instances driven in lockstep.
module tb_command_stream_unpacker;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        fl;
    logic        rv;
    logic [2:0]  rb;
    logic        pk;
    logic        e_ir;
    logic        e_rr;
    logic        e_ov;
    logic [31:0] e_be;
    logic [31:0] e_le;
    logic        e_err;
    logic [3:0]  e_lvl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, req_valid, req_peek;
  logic [31:0] in_data;
  logic [2:0]  req_bytes;

  logic        be_in_ready, be_req_ready, be_out_valid, be_req_err;
  logic [31:0] be_out_data;
  logic [3:0]  be_level;
  logic        le_in_ready, le_req_ready, le_out_valid, le_req_err;
  logic [31:0] le_out_data;
  logic [3:0]  le_level;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  command_stream_unpacker #(.BIG_ENDIAN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(be_in_ready),
    .in_data(in_data), .flush(flush), .req_valid(req_valid), .req_bytes(req_bytes),
    .req_peek(req_peek), .req_ready(be_req_ready), .out_valid(be_out_valid),
    .out_data(be_out_data), .req_err(be_req_err), .level(be_level)
  );

  command_stream_unpacker #(.BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(le_in_ready),
    .in_data(in_data), .flush(flush), .req_valid(req_valid), .req_bytes(req_bytes),
    .req_peek(req_peek), .req_ready(le_req_ready), .out_valid(le_out_valid),
    .out_data(le_out_data), .req_err(le_req_err), .level(le_level)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: actual %h required %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] id, input logic fl, input logic rv,
                     input logic [2:0] rb, input logic pk, input logic e_ir, input logic e_rr,
                     input logic e_ov, input logic [31:0] e_be, input logic [31:0] e_le,
                     input logic e_err, input logic [3:0] e_lvl);
    vec_t v;
    v = '{iv, id, fl, rv, rb, pk, e_ir, e_rr, e_ov, e_be, e_le, e_err, e_lvl};
    tv.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [31:0] id, input logic fl,
                       input logic rv, input logic [2:0] rb, input logic pk);
    in_valid  = iv;
    in_data   = id;
    flush     = fl;
    req_valid = rv;
    req_bytes = rb;
    req_peek  = pk;
  endtask

  task automatic chk_regs(input int idx, input logic ov, input logic [31:0] be,
                          input logic [31:0] le, input logic err, input logic [3:0] lvl);
    chk("out_valid", idx, 32'(be_out_valid), 32'(ov));
    chk("out_valid_le", idx, 32'(le_out_valid), 32'(ov));
    chk("out_data_be", idx, be_out_data, be);
    chk("out_data_le", idx, le_out_data, le);
    chk("req_err", idx, 32'(be_req_err), 32'(err));
    chk("level", idx, 32'(be_level), 32'(lvl));
    chk("level_le", idx, 32'(le_level), 32'(lvl));
  endtask

  initial begin
    //   iv id           fl rv rb pk  ir rr ov be           le           err lvl
    add(1, 32'h44332211, 0, 0, 0, 0,  1, 0, 0, 32'h0,       32'h0,       0, 4);
    add(1, 32'h88776655, 0, 0, 0, 0,  1, 0, 0, 32'h0,       32'h0,       0, 8);
    add(0, 32'h0,        0, 1, 1, 0,  0, 1, 1, 32'h11,      32'h11,      0, 7);
    add(0, 32'h0,        0, 1, 2, 0,  0, 1, 1, 32'h2233,    32'h3322,    0, 5);
    add(0, 32'h0,        0, 1, 4, 0,  0, 1, 1, 32'h44556677, 32'h77665544, 0, 1);
    add(1, 32'hdeadbeef, 1, 1, 1, 0,  0, 0, 0, 32'h44556677, 32'h77665544, 0, 0);
    add(1, 32'h44332211, 0, 0, 0, 0,  1, 0, 0, 32'h44556677, 32'h77665544, 0, 4);
    add(1, 32'h88776655, 0, 1, 3, 0,  1, 1, 1, 32'h112233,  32'h332211,  0, 5);
    add(0, 32'h0,        0, 1, 2, 0,  0, 1, 1, 32'h4455,    32'h5544,    0, 3);
    for (int i = 0; i < 3; i++)
      add(0, 32'h0,      0, 1, 4, 0,  1, 0, 0, 32'h4455,    32'h5544,    0, 3);
    add(1, 32'hddccbbaa, 0, 1, 4, 0,  1, 0, 0, 32'h4455,    32'h5544,    0, 7);
    add(0, 32'h0,        0, 1, 4, 0,  0, 1, 1, 32'h667788aa, 32'haa887766, 0, 3);
    add(1, 32'h04030201, 0, 0, 0, 0,  1, 0, 0, 32'h667788aa, 32'haa887766, 0, 7);
    add(0, 32'h0,        0, 1, 1, 0,  0, 1, 1, 32'hbb,      32'hbb,      0, 6);
    add(1, 32'h12345678, 1, 1, 2, 0,  0, 0, 0, 32'hbb,      32'hbb,      0, 0);
    add(0, 32'h0,        0, 1, 0, 0,  1, 1, 1, 32'h0,       32'h0,       0, 0);
    add(1, 32'h44332211, 0, 0, 0, 0,  1, 0, 0, 32'h0,       32'h0,       0, 4);
    add(0, 32'h0,        0, 1, 2, 1,  1, 1, 1, 32'h1122,    32'h2211,    0, 4);
    add(0, 32'h0,        0, 1, 2, 0,  1, 1, 1, 32'h1122,    32'h2211,    0, 2);
    add(1, 32'h88776655, 0, 1, 2, 0,  1, 1, 1, 32'h3344,    32'h4433,    0, 4);
    add(1, 32'hccbbaa99, 0, 0, 0, 0,  1, 0, 0, 32'h3344,    32'h4433,    0, 8);
    add(0, 32'h0,        0, 1, 7, 0,  0, 1, 1, 32'h55667788, 32'h88776655, 1, 4);
    add(0, 32'h0,        0, 1, 7, 0,  1, 1, 1, 32'h99aabbcc, 32'hccbbaa99, 1, 0);
    add(1, 32'h44332211, 0, 0, 0, 0,  1, 0, 0, 32'h99aabbcc, 32'hccbbaa99, 0, 4);

    reset = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_regs(-1, 0, 32'h0, 32'h0, 0, 4'd0);
    chk("in_ready_rst", -1, 32'(be_in_ready), 32'd1);

    @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].iv, tv[i].id, tv[i].fl, tv[i].rv, tv[i].rb, tv[i].pk);
      #1;
      chk("in_ready", i, 32'(be_in_ready), 32'(tv[i].e_ir));
      chk("req_ready", i, 32'(be_req_ready), 32'(tv[i].e_rr));
      chk("req_ready_le", i, 32'(le_req_ready), 32'(tv[i].e_rr));
      @(posedge clk);
      #1;
      chk_regs(i, tv[i].e_ov, tv[i].e_be, tv[i].e_le, tv[i].e_err, tv[i].e_lvl);
      @(negedge clk);
    end

    // Reset in mid-stream with a grantable request and a push both pending.
    reset = 1'b1;
    drive(1, 32'h87654321, 0, 1, 2, 0);
    @(posedge clk);
    #1;
    chk_regs(100, 0, 32'h0, 32'h0, 0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 0);
    #1;
    chk("in_ready_post_rst", 101, 32'(be_in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk_regs(101, 0, 32'h0, 32'h0, 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
